// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues in-order instruction memory requests and
// buffers returned words for decode under a valid/ready handshake.
// Optional feature macro: FETCH_BYPASS_EN (combinational response bypass
// into the decode-side outputs when the instruction queue is empty).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [31:0]   pc_q, pc_d;

  // Address queue: one entry per granted request awaiting its response.
  logic [31:0]   aq_mem [DEPTH];
  logic [PW-1:0] aq_wptr_q, aq_rptr_q;
  logic [CW-1:0] out_cnt_q, out_cnt_d;

  // Instruction queue of {pc, word}.
  logic [31:0]   iq_pc   [DEPTH];
  logic [31:0]   iq_word [DEPTH];
  logic [PW-1:0] iq_wptr_q, iq_rptr_q;
  logic [CW-1:0] q_cnt_q, q_cnt_d;

  // Responses still to be discarded after a redirect.
  logic [CW-1:0] drop_q, drop_d;

  logic credit_ok, grant, resp, resp_keep, q_empty;
  logic iq_push, iq_pop, bypass_fire;

  // Outstanding requests plus queued words never exceed DEPTH, so the sum
  // fits CW bits and the response push can never overflow the queue.
  assign credit_ok = (out_cnt_q + q_cnt_q) < DEPTH_C;
  assign imem_req  = rst_n & credit_ok;
  assign imem_addr = pc_q;
  assign grant     = imem_req & imem_gnt;
  assign resp      = imem_rvalid & (out_cnt_q != '0);
  assign resp_keep = resp & (drop_q == '0) & ~redirect;
  assign q_empty   = (q_cnt_q == '0);
  assign iq_push   = resp_keep & ~bypass_fire;
  assign iq_pop    = ~q_empty & instr_ready;

  // Decode-side outputs from the queue head, optionally bypassing a fresh response.
  always_comb begin
    instr_valid = ~q_empty;
    instr       = iq_word[iq_rptr_q];
    instr_pc    = iq_pc[iq_rptr_q];
    bypass_fire = 1'b0;
`ifdef FETCH_BYPASS_EN
    if (q_empty && resp_keep) begin
      instr_valid = 1'b1;
      instr       = imem_rdata;
      instr_pc    = aq_mem[aq_rptr_q];
      bypass_fire = instr_ready;
    end
`endif
  end

  // Next-state for PC, occupancy counters and the drop counter.
  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = {redirect_pc[31:2], 2'b00};
    end else if (grant) begin
      pc_d = pc_q + 32'd4;
    end

    out_cnt_d = out_cnt_q;
    if (grant && !resp) begin
      out_cnt_d = out_cnt_q + CNT_ONE;
    end else if (!grant && resp) begin
      out_cnt_d = out_cnt_q - CNT_ONE;
    end

    q_cnt_d = q_cnt_q;
    if (redirect) begin
      q_cnt_d = '0;
    end else if (iq_push && !iq_pop) begin
      q_cnt_d = q_cnt_q + CNT_ONE;
    end else if (!iq_push && iq_pop) begin
      q_cnt_d = q_cnt_q - CNT_ONE;
    end

    drop_d = drop_q;
    if (redirect) begin
      // Everything still in flight after this edge belongs to the old path.
      drop_d = out_cnt_d;
    end else if (resp && (drop_q != '0)) begin
      drop_d = drop_q - CNT_ONE;
    end
  end

  // PC and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      out_cnt_q <= '0;
      q_cnt_q   <= '0;
      drop_q    <= '0;
    end else begin
      pc_q      <= pc_d;
      out_cnt_q <= out_cnt_d;
      q_cnt_q   <= q_cnt_d;
      drop_q    <= drop_d;
    end
  end

  // Address queue: push PC on grant, pop on every response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aq_wptr_q <= '0;
      aq_rptr_q <= '0;
    end else begin
      if (grant) begin
        aq_mem[aq_wptr_q] <= pc_q;
        aq_wptr_q         <= aq_wptr_q + PTR_ONE;
      end
      if (resp) begin
        aq_rptr_q <= aq_rptr_q + PTR_ONE;
      end
    end
  end

  // Instruction queue storage and pointers; a redirect empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iq_wptr_q <= '0;
      iq_rptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        iq_pc[i]   <= '0;
        iq_word[i] <= '0;
      end
    end else if (redirect) begin
      iq_wptr_q <= '0;
      iq_rptr_q <= '0;
    end else begin
      if (iq_push) begin
        iq_pc[iq_wptr_q]   <= aq_mem[aq_rptr_q];
        iq_word[iq_wptr_q] <= imem_rdata;
        iq_wptr_q          <= iq_wptr_q + PTR_ONE;
      end
      if (iq_pop) begin
        iq_rptr_q <= iq_rptr_q + PTR_ONE;
      end
    end
  end

  // A response with nothing outstanding is a memory protocol violation.
  rvalid_has_req: assert property (@(posedge clk) disable iff (!rst_n)
                                   imem_rvalid |-> (out_cnt_q != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: reset, streaming, backpressure,
// redirects, PC wrap and asynchronous reset mid-stream.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] KEY      = 32'hA5A5_A5A5;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  // Memory: either an automatic 1-cycle model or manual drive from the sequence.
  logic        auto_mem;
  logic        man_gnt, man_rvalid;
  logic [31:0] man_rdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int n_vec = 0;
  int n_err = 0;

  assign imem_gnt    = auto_mem ? 1'b1 : man_gnt;
  assign imem_rvalid = auto_mem ? mem_rvalid : man_rvalid;
  assign imem_rdata  = auto_mem ? mem_rdata : man_rdata;

  fetch_unit #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1-cycle memory returning addr ^ KEY for every grant.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rvalid <= 1'b0;
      mem_rdata  <= '0;
    end else begin
      mem_rvalid <= imem_req & imem_gnt;
      mem_rdata  <= imem_addr ^ KEY;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  // Wait (bounded) for instr_valid with instr_ready high, return the head, let it transfer.
  task automatic get_instr(input string tag, output logic [31:0] pc, output logic [31:0] w);
    int n;
    n = 0;
    while (instr_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    pc = instr_pc;
    w  = instr;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] pc, w;
    int grants;

    rst_n = 1'b0; auto_mem = 1'b1; man_gnt = 1'b0; man_rvalid = 1'b0; man_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req",   {31'd0, imem_req},    32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr,                32'd0);
    chk("rst_ipc",   instr_pc,             32'd0);
    chk("rst_addr",  imem_addr,            RESET_PC);

`ifndef FETCH_BYPASS_EN
    // Streaming from reset: first valid two cycles after first grant
    do_reset();
    chk("s_req0",   {31'd0, imem_req},    32'd1);
    chk("s_addr0",  imem_addr,            32'hBFC0_0000);
    chk("s_valid0", {31'd0, instr_valid}, 32'd0);
    step();
    chk("s_valid1", {31'd0, instr_valid}, 32'd0);
    chk("s_addr1",  imem_addr,            32'hBFC0_0004);
    step();
    chk("s_valid2", {31'd0, instr_valid}, 32'd1);
    chk("s_pc2",    instr_pc,             32'hBFC0_0000);
    chk("s_w2",     instr,                32'h1A65_A5A5);
    chk("s_req2",   {31'd0, imem_req},    32'd0);
    step();
    chk("s_valid3", {31'd0, instr_valid}, 32'd1);
    chk("s_pc3",    instr_pc,             32'hBFC0_0004);
    chk("s_w3",     instr,                32'h1A65_A5A1);
    step();
    get_instr("s_third", pc, w);
    chk("s_pc_third", pc, 32'hBFC0_0008);
    chk("s_w_third",  w,  32'h1A65_A5AD);
`endif

    // Backpressure: exactly DEPTH grants, then words delivered in order
    instr_ready = 1'b0;
    do_reset();
    grants = 0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req === 1'b1) grants++;
      step();
    end
    chk("bp_grants", grants,              DEPTH);
    chk("bp_req",    {31'd0, imem_req},   32'd0);
    chk("bp_hold",   instr_pc,            32'hBFC0_0000);
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      get_instr("bp_get", pc, w);
      chk("bp_pc",   pc, RESET_PC + 32'(4 * i));
      chk("bp_word", w,  (RESET_PC + 32'(4 * i)) ^ KEY);
    end

`ifndef FETCH_BYPASS_EN
    // Redirect with two outstanding requests
    auto_mem = 1'b0; man_gnt = 1'b1; man_rvalid = 1'b0;
    do_reset();
    step();
    chk("r1_addr", imem_addr, 32'hBFC0_0004);
    step();
    chk("r1_req_full", {31'd0, imem_req}, 32'd0);
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0;
    chk("r1_addr_new", imem_addr,            32'h0000_0100);
    chk("r1_valid_a",  {31'd0, instr_valid}, 32'd0);
    man_rvalid = 1'b1; man_rdata = 32'hDEAD_0000;
    step();
    chk("r1_valid_b", {31'd0, instr_valid}, 32'd0);
    man_rdata = 32'hDEAD_0004;
    step();
    chk("r1_valid_c", {31'd0, instr_valid}, 32'd0);
    chk("r1_addr2",   imem_addr,            32'h0000_0104);
    man_rdata = 32'h1234_5678;
    step();
    chk("r1_valid_d", {31'd0, instr_valid}, 32'd1);
    chk("r1_pc",      instr_pc,             32'h0000_0100);
    chk("r1_word",    instr,                32'h1234_5678);
    man_rvalid = 1'b0; man_gnt = 1'b0;

    // Redirect in the same cycle as a grant and a response
    man_gnt = 1'b1;
    do_reset();
    step();
    man_rvalid = 1'b1; man_rdata = 32'h0BAD_0000;
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    chk("r2_valid_a", {31'd0, instr_valid}, 32'd0);
    chk("r2_req",     {31'd0, imem_req},    32'd1);
    step();
    redirect = 1'b0;
    chk("r2_valid_b", {31'd0, instr_valid}, 32'd0);
    chk("r2_addr",    imem_addr,            32'h0000_0200);
    man_rdata = 32'h0BAD_0004;
    step();
    chk("r2_valid_c", {31'd0, instr_valid}, 32'd0);
    chk("r2_addr2",   imem_addr,            32'h0000_0204);
    man_rdata = 32'hCAFE_0200; man_gnt = 1'b0;
    step();
    chk("r2_valid_d", {31'd0, instr_valid}, 32'd1);
    chk("r2_pc",      instr_pc,             32'h0000_0200);
    chk("r2_word",    instr,                32'hCAFE_0200);
    man_rvalid = 1'b0;
`endif

    // PC wrap at 0xFFFF_FFFC, then async reset mid-stream
    auto_mem = 1'b0; man_gnt = 1'b0; man_rvalid = 1'b0;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    do_reset();
    step();
    redirect = 1'b0;
    chk("w_addr_top", imem_addr, 32'hFFFF_FFFC);
    auto_mem = 1'b1;
    step();
    chk("w_addr_wrap", imem_addr, 32'h0000_0000);
    get_instr("w_a", pc, w);
    chk("w_pc_a", pc, 32'hFFFF_FFFC);
    chk("w_w_a",  w,  32'h5A5A_5A59);
    get_instr("w_b", pc, w);
    chk("w_pc_b", pc, 32'h0000_0000);
    chk("w_w_b",  w,  32'hA5A5_A5A5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'd0, instr_valid}, 32'd0);
    chk("ar_req",   {31'd0, imem_req},    32'd0);
    chk("ar_ipc",   instr_pc,             32'd0);
    chk("ar_addr",  imem_addr,            RESET_PC);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ar_req_rel", {31'd0, imem_req}, 32'd1);
    get_instr("ar_first", pc, w);
    chk("ar_pc",   pc, RESET_PC);
    chk("ar_word", w,  RESET_PC ^ KEY);

`ifdef FETCH_BYPASS_EN
    // Bypass: response into an empty queue is visible in the same cycle
    auto_mem = 1'b1; instr_ready = 1'b1;
    do_reset();
    step();
    chk("by_valid", {31'd0, instr_valid}, 32'd1);
    chk("by_pc",    instr_pc,             32'hBFC0_0000);
    chk("by_word",  instr,                32'h1A65_A5A5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
